// File: rtl/mac_tile_mk_pkg.sv
// rtl/mac_tile_mk_pkg.sv - shared state encoding, mode constants and operand extension for mac_tile_mk
package mac_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic MODE_WS = 1'b1;
  localparam logic MODE_OS = 1'b0;

  // Widen a bw-bit value (bw <= 32) to 64 bits, replicating the MSB when sgn is set.
  function automatic logic [63:0] ext(input logic [31:0] v, input int bw, input logic sgn);
    logic [63:0] r;
    logic        msb;
    msb = sgn & v[5'(bw - 1)];
    for (int i = 0; i < 64; i++) begin
      r[i] = (i < bw) ? v[i[4:0]] : msb;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_tile_mk_unit_ext.sv
// rtl/mac_tile_mk_unit_ext.sv - combinational multiply-add, optional saturation under MAC_TILE_MK_SAT_EN
module mac_unit_ext
  import mac_pkg::*;
#(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int SIGNED  = 1
) (
  input  logic [BW-1:0]      a,
  input  logic [BW-1:0]      b,
  input  logic [PSUM_BW-1:0] c,
  output logic [PSUM_BW-1:0] y
);

  localparam logic SGN = (SIGNED != 0);

  logic [PSUM_BW-1:0] ax;
  logic [PSUM_BW-1:0] bx;
  logic [PSUM_BW-1:0] prod;

  // Both operands are widened to the psum width first, so the truncated
  // product is already the correctly extended 2*BW-bit product.
  assign ax   = PSUM_BW'(ext(32'(a), BW, SGN));
  assign bx   = PSUM_BW'(ext(32'(b), BW, SGN));
  assign prod = ax * bx;

`ifdef MAC_TILE_MK_SAT_EN
  localparam logic [PSUM_BW-1:0] SMAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] SMIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  logic [PSUM_BW:0] sum;

  // Clamp the psum add to the representable range instead of wrapping.
  always_comb begin
    sum = {1'b0, c} + {1'b0, prod};
    y   = sum[PSUM_BW-1:0];
    if (SGN) begin
      if ((c[PSUM_BW-1] == prod[PSUM_BW-1]) && (sum[PSUM_BW-1] != c[PSUM_BW-1])) begin
        y = c[PSUM_BW-1] ? SMIN : SMAX;
      end
    end else if (sum[PSUM_BW]) begin
      y = '1;
    end
  end
`else
  // Plain modulo-2^PSUM_BW psum add.
  always_comb begin
    y = c + prod;
  end
`endif

endmodule

// File: rtl/mac_tile_mk.sv
// rtl/mac_tile_mk.sv - WS/OS systolic PE with weight bank and drain chain; MAC_TILE_MK_SAT_EN enables saturating adds
module mac_tile_mk
  import mac_pkg::*;
#(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int KDEPTH  = 4,
  parameter int SIGNED  = 1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             mode,
  input  logic [BW-1:0]                                    in_w,
  output logic [BW-1:0]                                    out_e,
  input  logic [1:0]                                       inst_w,
  output logic [1:0]                                       inst_e,
  input  logic [PSUM_BW-1:0]                               in_n,
  output logic [PSUM_BW-1:0]                               out_s,
  input  logic [(KDEPTH > 1 ? $clog2(KDEPTH) : 1)-1:0]     kslot,
  input  logic                                             overwrite,
  input  logic                                             flush,
  output logic                                             valid
);

  localparam int   KW  = (KDEPTH > 1) ? $clog2(KDEPTH) : 1;
  localparam logic SGN = (SIGNED != 0);

  state_t             state;
  state_t             state_nx;
  logic [KW-1:0]      ld_ptr;
  logic [BW-1:0]      w [KDEPTH];
  logic [PSUM_BW-1:0] acc;

  logic               ld_last;
  logic               load_we;
  logic               ptr_clr;
  logic               exec_ws;
  logic               comp_os;
  logic               drain_first;
  logic               drain_pass;

  logic [BW-1:0]      mac_b;
  logic [PSUM_BW-1:0] mac_c;
  logic [PSUM_BW-1:0] mac_y;
  logic [PSUM_BW-1:0] w_fwd;

  assign ld_last = (ld_ptr == KW'(KDEPTH - 1));
  assign w_fwd   = PSUM_BW'(ext(32'(in_n[BW-1:0]), BW, SGN));

  // One multiply-add serves both dataflows; mode is static so the mux never toggles mid-run.
  assign mac_b = (mode == MODE_WS) ? w[kslot] : in_n[BW-1:0];
  assign mac_c = (mode == MODE_WS) ? in_n : acc;

  mac_unit_ext #(
    .BW      (BW),
    .PSUM_BW (PSUM_BW),
    .SIGNED  (SIGNED)
  ) u_mac (
    .a (in_w),
    .b (mac_b),
    .c (mac_c),
    .y (mac_y)
  );

  // Next-state and per-cycle action strobes; overwrite beats load, flush beats compute.
  always_comb begin
    state_nx    = state;
    load_we     = 1'b0;
    ptr_clr     = 1'b0;
    exec_ws     = 1'b0;
    comp_os     = 1'b0;
    drain_first = 1'b0;
    drain_pass  = 1'b0;
    case (state)
      ST_LOAD: begin
        if (mode != MODE_WS) begin
          state_nx = ST_RUN;
        end else if (overwrite) begin
          ptr_clr = 1'b1;
        end else if (inst_w[0]) begin
          load_we = 1'b1;
          if (ld_last) state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mode == MODE_WS) begin
          exec_ws = inst_w[1];
          if (overwrite) begin
            ptr_clr  = 1'b1;
            state_nx = ST_LOAD;
          end
        end else if (flush) begin
          drain_first = 1'b1;
          state_nx    = ST_DRAIN;
        end else begin
          comp_os = inst_w[0];
        end
      end
      ST_DRAIN: begin
        if ((mode == MODE_OS) && flush) begin
          drain_pass = 1'b1;
        end else begin
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // State, weight bank, accumulator and all registered outputs toward east and south.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= (mode == MODE_WS) ? ST_LOAD : ST_RUN;
      ld_ptr <= '0;
      acc    <= '0;
      out_e  <= '0;
      inst_e <= '0;
      out_s  <= '0;
      valid  <= 1'b0;
      for (int i = 0; i < KDEPTH; i++) w[i] <= '0;
    end else begin
      state <= state_nx;
      valid <= 1'b0;
      if ((mode == MODE_WS) ? (|inst_w) : inst_w[0]) out_e <= in_w;
      // The load token is consumed here; only the execute bit travels east during loading.
      inst_e <= (state == ST_LOAD) ? {inst_w[1], 1'b0} : inst_w;
      if (ptr_clr) begin
        ld_ptr <= '0;
      end else if (load_we) begin
        w[ld_ptr] <= in_w;
        ld_ptr    <= ld_last ? '0 : ld_ptr + KW'(1);
      end
      if (exec_ws) out_s <= mac_y;
      if (comp_os) begin
        acc   <= mac_y;
        out_s <= w_fwd;
      end
      if (drain_first) begin
        out_s <= acc;
        valid <= 1'b1;
        acc   <= '0;
      end
      if (drain_pass) begin
        out_s <= in_n;
        valid <= 1'b1;
      end
    end
  end

endmodule
